fsm_ec1: RTL and testbench
==========================

// Module: fsm_ec1
// PURPOSE
//  Control unit (FSM) of the EC-1 8-bit accumulator CPU. Sequences fetch/decode/execute
//  from opcode IR[7:5] and the A!=0 status, and drives the datapath control strobes
//  (IR load, PC load, input mux, A load, JNZ mux, halt). Sits beside the EC-1 datapath,
//  which owns PC, IR, A, the PC+1 incrementer and the A-1 decrementer.
// PARAMETERS
//  OP_IN    3'b000  opcode: A <= input port
//  OP_OUT   3'b001  opcode: output A (datapath output always shows A; no strobe)
//  OP_DEC   3'b010  opcode: A <= A-1
//  OP_JNZ   3'b011  opcode: if A!=0 then PC <= IR[4:0]
//  OP_HALT  3'b100  opcode: stop
// PORTS
//  clk     in   1  system clock, rising edge
//  reset   in   1  asynchronous, active-low reset
//  Aneq0   in   1  datapath status: A != 0
//  ir75    in   3  opcode field IR[7:5]
//  IRload  out  1  load IR from memory[PC]
//  PCload  out  1  load PC (source chosen by JNZmux)
//  INmux   out  1  A-input mux: 1 = input port, 0 = A-1
//  Aload   out  1  load A
//  JNZmux  out  1  PC-input mux: 1 = IR[4:0], 0 = PC+1
//  Halt    out  1  CPU halted indicator
// BEHAVIOUR
//  - States (3-bit, binary): START, FETCH, DECODE, S_IN, S_OUT, S_DEC, S_JNZ, S_HALT.
//  - reset=0 (async): state <= START immediately; all outputs 0 while held.
//  - Transitions on rising clk when reset=1:
//      START->FETCH; FETCH->DECODE;
//      DECODE->S_IN/S_OUT/S_DEC/S_JNZ/S_HALT per ir75 (sampled in DECODE);
//      DECODE with ir75 = 101/110/111 (undefined) -> FETCH (NOP, no strobes);
//      S_IN, S_OUT, S_DEC, S_JNZ -> FETCH; S_HALT -> S_HALT until reset.
//  - Outputs combinational from state (all others 0):
//      FETCH: IRload=1, PCload=1, JNZmux=0 (IR<=mem[PC], PC<=PC+1)
//      S_IN:  INmux=1, Aload=1
//      S_DEC: INmux=0, Aload=1
//      S_JNZ: JNZmux=1, PCload=Aneq0 (Mealy on Aneq0; only input-dependent output)
//      S_HALT: Halt=1
//      START, DECODE, S_OUT: all 0
//  - Latency: 3 clocks per instruction (FETCH, DECODE, execute); first FETCH is the
//    2nd clock after reset release.
//  - ir75 ignored outside DECODE; Aneq0 ignored outside S_JNZ.
//  - Reset mid-instruction (any state, incl. S_HALT): abort to START, outputs 0.
//  - Outputs glitch-free from registered state except PCload in S_JNZ.
// TESTING
//  1 Hold reset=0 100ns (clk 20ns), then reset=1 -> START, FETCH(IRload=PCload=1),
//    DECODE sequence; all outputs 0 during reset.
//  2 ir75=000 at DECODE -> next cycle INmux=1,Aload=1, then FETCH; ir75=010 -> Aload=1,
//    INmux=0.
//  3 ir75=011, Aneq0=1 -> S_JNZ: JNZmux=1,PCload=1; with Aneq0=0 -> JNZmux=1,PCload=0;
//    toggle Aneq0 inside S_JNZ -> PCload follows combinationally.
//  4 ir75=100 -> Halt=1 held for 10+ cycles regardless of ir75/Aneq0; reset=0 clears
//    to START asynchronously (no clk edge).
//  5 ir75=110 (and 101,111) at DECODE -> FETCH next cycle, no Aload/PCload in between;
//    ir75=001 -> one all-zero cycle then FETCH.
//  6 Assert reset=0 mid-cycle in FETCH -> IRload/PCload drop before next clk edge.

Source files
------------

// File: rtl/fsm_ec1.sv
// EC-1 accumulator CPU control unit.
// Sequences fetch/decode/execute and drives datapath strobes.
module fsm_ec1 (
  input  logic       clk,
  input  logic       reset,
  input  logic       Aneq0,
  input  logic [2:0] ir75,
  output logic       IRload,
  output logic       PCload,
  output logic       INmux,
  output logic       Aload,
  output logic       JNZmux,
  output logic       Halt
);

  localparam logic [2:0] OP_IN   = 3'b000;
  localparam logic [2:0] OP_OUT  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    S_IN   = 3'd3,
    S_OUT  = 3'd4,
    S_DEC  = 3'd5,
    S_JNZ  = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t state, nxt;

  // State register; reset aborts any instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= nxt;
  end

  // Next-state logic; opcode only matters in DECODE.
  always_comb begin
    nxt = state;
    unique case (state)
      START:  nxt = FETCH;
      FETCH:  nxt = DECODE;
      DECODE: begin
        nxt = FETCH;
        unique case (1'b1)
          (ir75 == OP_IN):   nxt = S_IN;
          (ir75 == OP_OUT):  nxt = S_OUT;
          (ir75 == OP_DEC):  nxt = S_DEC;
          (ir75 == OP_JNZ):  nxt = S_JNZ;
          (ir75 == OP_HALT): nxt = S_HALT;
          default:           nxt = FETCH;
        endcase
      end
      S_IN:   nxt = FETCH;
      S_OUT:  nxt = FETCH;
      S_DEC:  nxt = FETCH;
      S_JNZ:  nxt = FETCH;
      S_HALT: nxt = S_HALT;
      default: nxt = START;
    endcase
  end

  // Strobes decoded from state; PCload in S_JNZ follows Aneq0.
  always_comb begin
    IRload = 1'b0;
    PCload = 1'b0;
    INmux  = 1'b0;
    Aload  = 1'b0;
    JNZmux = 1'b0;
    Halt   = 1'b0;
    unique case (state)
      FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_IN: begin
        INmux = 1'b1;
        Aload = 1'b1;
      end
      S_DEC: Aload = 1'b1;
      S_JNZ: begin
        JNZmux = 1'b1;
        PCload = Aneq0;
      end
      S_HALT: Halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_ec1.sv
// Randomized scoreboard bench for fsm_ec1.
// Expected strobes per cycle are queued; a monitor compares.
module tb_fsm_ec1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Aneq0 = 1'b0;
  logic [2:0] ir75 = 3'b000;
  logic       IRload, PCload, INmux, Aload, JNZmux, Halt;
  logic [5:0] act;

  typedef struct {
    logic [5:0] v;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   tagn = 0;

  fsm_ec1 dut (
    .clk(clk), .reset(reset), .Aneq0(Aneq0), .ir75(ir75),
    .IRload(IRload), .PCload(PCload), .INmux(INmux),
    .Aload(Aload), .JNZmux(JNZmux), .Halt(Halt)
  );

  assign act = {IRload, PCload, INmux, Aload, JNZmux, Halt};

  always #10 clk = ~clk;

  // Vector order: IRload PCload INmux Aload JNZmux Halt
  function automatic logic [5:0] exec_exp(int op, logic a);
    case (op)
      0: return 6'b001100;
      1: return 6'b000000;
      2: return 6'b000100;
      3: return {1'b0, a, 3'b001, 1'b0};
      default: return 6'b000001;
    endcase
  endfunction

  task automatic push(logic [5:0] v);
    exp_t e;
    e.v = v;
    e.tag = tagn;
    tagn++;
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [5:0] a, logic [5:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, a, e, $time);
    end
  endtask

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL scb tag=%0d actual=%b required=%b t=%0t",
                   e.tag, act, e.v, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      ir75 = 3'($urandom);
      Aneq0 = 1'($urandom);
      chk("in_reset", act, 6'b0);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    push(6'b0);
  endtask

  task automatic instr(int op);
    logic a;
    @(posedge clk);
    #2;
    ir75 = 3'($urandom);
    Aneq0 = 1'($urandom);
    push(6'b110000);
    @(posedge clk);
    #2;
    ir75 = 3'(op);
    Aneq0 = 1'($urandom);
    push(6'b0);
    if (op <= 3) begin
      @(posedge clk);
      #2;
      a = 1'($urandom);
      Aneq0 = a;
      ir75 = 3'($urandom);
      push(exec_exp(op, a));
      if (op == 3 && $urandom_range(1, 0) == 1) begin
        #10;
        Aneq0 = ~a;
        #1;
        chk("jnz_toggle", act, {1'b0, ~a, 3'b001, 1'b0});
      end
    end
  endtask

  task automatic halt_and_reset();
    instr(4);
    repeat (12) begin
      @(posedge clk);
      #2;
      ir75 = 3'($urandom);
      Aneq0 = 1'($urandom);
      push(6'b000001);
    end
    @(posedge clk);
    #4;
    chk("halt_hold", act, 6'b000001);
    #1;
    reset = 1'b0;
    #1;
    chk("halt_async_rst", act, 6'b0);
  endtask

  task automatic fetch_reset();
    @(posedge clk);
    #3;
    chk("fetch_pre_rst", act, 6'b110000);
    #2;
    reset = 1'b0;
    #1;
    chk("fetch_async_rst", act, 6'b0);
  endtask

  task automatic run_block(int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(7, 0);
      if (op == 4) op = $urandom_range(3, 0);
      instr(op);
    end
  endtask

  initial begin
    for (int op = 0; op < 8; op++) begin
      if (op == 4) continue;
      do_reset();
      instr(op);
      instr(3);
      fetch_reset();
    end
    for (int b = 0; b < 6; b++) begin
      do_reset();
      run_block(25);
      if (b % 2 == 0) halt_and_reset();
      else fetch_reset();
    end
    do_reset();
    run_block(10);
    halt_and_reset();
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
